// File: rtl/buffet_ctrl_v2.sv
// buffet_ctrl_v2: buffet storage, controller and credit logic in one block.
// Elements are filled in order by a credit-driven producer. The consumer
// reads them by index relative to the oldest entry, optionally marking a
// slot for a later in-place update, and shrinks the window to free slots.
// Optional feature macro: BUFFET_UPDATE_EN enables the update port and the
// per-slot pending scoreboard. Without it, update_ready is tied low and the
// update inputs are ignored.
//
// Handshake rule for every channel: a transfer happens on the rising clk
// edge where valid and ready are both 1. A valid never waits on its ready.
// read_data_valid stays high with read_data stable until read_data_ready.
module buffet_ctrl_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  nreset_i,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_data_valid,
  output logic                  push_data_ready,
  input  logic [IDX_WIDTH-1:0]  read_idx,
  input  logic                  read_will_update,
  input  logic                  is_shrink,
  input  logic                  read_idx_valid,
  output logic                  read_idx_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_valid,
  input  logic                  read_data_ready,
  input  logic [IDX_WIDTH-1:0]  update_idx,
  input  logic [DATA_WIDTH-1:0] update_data,
  input  logic                  update_valid,
  output logic                  update_ready,
  output logic [IDX_WIDTH:0]    credit_out,
  output logic                  credit_valid,
  input  logic                  credit_ready
);
  localparam int SIZE = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH:0] SIZE_L = {1'b1, {IDX_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [IDX_WIDTH-1:0]  head;
  logic [IDX_WIDTH-1:0]  tail;
  logic [IDX_WIDTH:0]    occ;
  logic [IDX_WIDTH:0]    cacc;

  logic                  fill_acc;
  logic                  rd_acc;
  logic                  sh_acc;
  logic                  rd_ok;
  logic                  sh_ok;
  logic                  rd_pend;
  logic                  shrink_blocked;
  logic [IDX_WIDTH-1:0]  rd_slot;
  logic [IDX_WIDTH:0]    shrink_amt;
  logic [IDX_WIDTH:0]    idx_ext;

  assign idx_ext         = {1'b0, read_idx};
  assign rd_slot         = head + read_idx;
  assign push_data_ready = (occ != SIZE_L);
  assign fill_acc        = push_data_valid & push_data_ready;

  // The response register may be refilled in the cycle it is consumed,
  // so back-to-back reads run at full rate while read_data_ready stays 1.
  assign rd_ok = (idx_ext < occ) && !rd_pend && (!read_data_valid || read_data_ready);
  assign sh_ok = (idx_ext <= occ) && !shrink_blocked;

  assign read_idx_ready = is_shrink ? sh_ok : rd_ok;
  assign rd_acc         = read_idx_valid & ~is_shrink & rd_ok;
  assign sh_acc         = read_idx_valid & is_shrink & sh_ok;
  assign shrink_amt     = sh_acc ? idx_ext : '0;

  assign credit_out   = cacc;
  assign credit_valid = (cacc != '0);

`ifdef BUFFET_UPDATE_EN
  logic [SIZE-1:0]      pending;
  logic                 upd_acc;
  logic [IDX_WIDTH-1:0] upd_slot;

  assign update_ready = 1'b1;
  assign upd_acc      = update_valid;
  assign upd_slot     = head + update_idx;
  assign rd_pend      = pending[rd_slot];

  // A shrink may not retire any slot still awaiting its update.
  always_comb begin
    shrink_blocked = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if ((i < int'(read_idx)) && pending[head + IDX_WIDTH'(i)]) begin
        shrink_blocked = 1'b1;
      end
    end
  end

  // Pending scoreboard: updates clear first, then a read-will-update sets.
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      pending <= '0;
    end else begin
      if (upd_acc) pending[upd_slot] <= 1'b0;
      if (rd_acc && read_will_update) pending[rd_slot] <= 1'b1;
    end
  end

  // Storage writes: the update is last so it wins a same-slot collision.
  always_ff @(posedge clk) begin
    if (fill_acc) mem[tail] <= push_data;
    if (upd_acc) mem[upd_slot] <= update_data;
  end
`else
  logic unused_update;

  assign update_ready   = 1'b0;
  assign rd_pend        = 1'b0;
  assign shrink_blocked = 1'b0;
  assign unused_update  = &{1'b0, read_will_update, update_idx, update_data, update_valid};

  // Storage writes from the fill path only.
  always_ff @(posedge clk) begin
    if (fill_acc) mem[tail] <= push_data;
  end
`endif

  // Window pointers, occupancy and credit accumulator.
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      cacc <= SIZE_L;
    end else begin
      if (fill_acc) tail <= tail + 1'b1;
      if (sh_acc) head <= head + read_idx;
      occ <= occ + {{IDX_WIDTH{1'b0}}, fill_acc} - shrink_amt;
      if (credit_valid && credit_ready) cacc <= shrink_amt;
      else cacc <= cacc + shrink_amt;
    end
  end

  // Single read-response register with hold-until-accepted behaviour.
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else if (rd_acc) begin
      read_data       <= mem[rd_slot];
      read_data_valid <= 1'b1;
    end else if (read_data_ready) begin
      read_data_valid <= 1'b0;
    end
  end

endmodule
